alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered ALU that succeeds the per-bit combinational ALU slice.
- Single-cycle ops: AND, OR, ADD, SUB, SLT, SRL.
- Iterative shift-add unsigned multiply (MULTU) with HI/LO result registers, read back via MFHI/MFLO.
- Sits between the register-file read stage and write-back; a start/busy/done handshake lets the controller stall during multiplication.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), derived width of the shift-amount field.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  operation request; sampled only when busy=0
- dataA  input  WIDTH  operand A
- dataB  input  WIDTH  operand B; low SHW bits are the SRL shift amount
- Signal  input  6  operation code (funct-style), sampled with start
- dataOut  output  WIDTH  registered result
- zero  output  1  registered, =1 when dataOut==0
- overflow  output  1  registered signed overflow (ADD/SUB only, else 0)
- busy  output  1  =1 while a MULTU is iterating
- done  output  1  one-cycle pulse when dataOut/HI/LO are final

Behaviour:
- Op codes:
  - ADD=6'd32, SUB=6'd34, AND=6'd36, OR=6'd37, SLT=6'd42, SRL=6'd2, MULTU=6'd25, MFHI=6'd16, MFLO=6'd18.
- Reset values: dataOut=0, zero=1, overflow=0, busy=0, done=0, HI=0, LO=0, state=IDLE, iteration counter=0.
- States: IDLE, MUL, FIN.
  - IDLE & start & Signal!=MULTU: result computed and registered at the edge; done=1 in the following cycle (latency 1); stays IDLE.
  - IDLE & start & Signal==MULTU: latch A (multiplicand), B (multiplier), clear 2*WIDTH product accumulator, count=0, busy=1 → MUL.
  - MUL: one shift-add step per cycle (if multiplier LSB, add multiplicand into upper half; shift right); count increments. When count reaches WIDTH-1, the step completes → FIN. Busy is high for exactly WIDTH cycles.
  - FIN: HI/LO written from the product, dataOut=LO, busy=0, done=1 for this single cycle → IDLE. Latency from start = WIDTH+1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow=1 when operand signs (B inverted for SUB) match and the result sign differs.
  - SLT: signed compare, result = sign(A-B) XOR overflow(A-B), zero-extended to WIDTH.
  - SRL: logical right shift by dataB[SHW-1:0].
  - MFHI/MFLO: dataOut=HI/LO, latency 1, overflow=0.
- Boundary conditions:
  - start while busy=1: ignored; no state, HI/LO or done effect.
  - Unknown Signal: dataOut=0, zero=1, overflow=0, done pulses; HI/LO unchanged.
  - done is 0 in every cycle not listed above; back-to-back single-cycle ops yield back-to-back done pulses.
  - rst during MUL (any cycle): abort immediately; all registers take reset values; no done pulse.
  - rst and start in the same cycle: rst wins; the request is dropped.
  - zero and overflow update only on the edge that produces done, and hold between operations.

Decomposition:
- Shared package alu_pkg: the 6-bit op-code localparams above, the state encoding (IDLE/MUL/FIN), and the default WIDTH.
- One natural sub-module, multu_iter: the multiplicand/product registers, iteration counter and shift-add step, with its own load/step/last ports.
- Single-cycle datapath and FSM remain in alu_seq.

Test Plan:
- ADD A=0x7FFFFFFF, B=0x00000001, start 1 cycle → next cycle dataOut=0x80000000, overflow=1, zero=0, done=1 for one cycle.
- SLT A=0xFFFFFFFF, B=0x00000001 → dataOut=1. SLT A=0x80000000, B=0x7FFFFFFF (overflowing subtraction) → dataOut=1. SUB A=5, B=5 → dataOut=0, zero=1.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → busy high 32 cycles, done at cycle 33 after start with dataOut=0x00000001. Then MFHI → 0xFFFFFFFE and MFLO → 0x00000001.
- During that MULTU, pulse start with ADD 1+1 at cycle 5 → ignored; no extra done; HI/LO as above.
- MULTU 3×7, rst asserted at cycle 10 → next cycle busy=0, done never pulses; a following MFLO returns 0.
- SRL A=0x80000000, dataB=31 → dataOut=0x00000001. Signal=6'h3F → dataOut=0, zero=1, done=1, HI/LO unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the registered sequential ALU.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width
//   OP_*           6-bit funct-style operation codes accepted on Signal
//   state_t        control FSM states (IDLE, MUL, FIN)

package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_multu_iter.sv
// Iterative shift-add unsigned multiplier core.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       capture a_in as multiplicand, b_in as multiplier, clear count
//   step       perform one shift-add iteration
//   a_in, b_in WIDTH-bit operands (used only with load)
//   last       high during the step that completes the product
//   product    2*WIDTH-bit product register

module multu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [SHW-1:0]     count_q, count_d;
    logic [WIDTH:0]     upper_sum;

    // The multiplier lives in the low half of the product register; its
    // consumed bits are shifted out as partial-product bits shift in, so
    // the accumulator starts as {0, multiplier}. The upper-half sum keeps
    // its carry so the shift cannot lose the top bit.
    always_comb begin
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        count_d   = count_q;
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});
        if (load) begin
            mcand_d = a_in;
            prod_d  = {{WIDTH{1'b0}}, b_in};
            count_d = '0;
        end else if (step) begin
            prod_d  = {upper_sum, prod_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

    assign last    = step && (count_q == LAST_CNT);
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arithmetic ops and an iterative
// unsigned multiply writing HI/LO.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      operation request, sampled only in IDLE
//   dataA      operand A
//   dataB      operand B (low SHW bits are the SRL shift amount)
//   Signal     6-bit operation code, sampled with start
//   dataOut    registered result
//   zero       registered, high when the last result was zero
//   overflow   registered signed overflow of the last ADD/SUB
//   busy       high while a MULTU is iterating
//   done       one-cycle pulse when the result (and HI/LO) are final

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             add_ovf, sub_ovf, alu_ovf;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_product;

    // Single-cycle datapath. Overflow follows the sign rule: operands of
    // equal sign (B inverted for SUB) giving a result of the other sign.
    // SLT reuses the subtract so that sign XOR overflow gives the true
    // signed comparison even when A-B overflows.
    always_comb begin
        sum     = dataA + dataB;
        diff    = dataA - dataB;
        add_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
        sub_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff[WIDTH-1] != dataA[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Signal)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_AND:  alu_res = dataA & dataB;
            OP_OR:   alu_res = dataA | dataB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            OP_SRL:  alu_res = dataA >> dataB[SHW-1:0];
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign mul_load = (state_q == ST_IDLE) && start && (Signal == OP_MULTU);
    assign mul_step = (state_q == ST_MUL);

    multu_iter #(
        .WIDTH (WIDTH)
    ) u_multu_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a_in    (dataA),
        .b_in    (dataB),
        .last    (mul_last),
        .product (mul_product)
    );

    // Control FSM. Result flags change only on edges that raise done.
    // FIN is a one-cycle bookkeeping state; requests there are not taken
    // because the controller waits for done before issuing again.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (Signal == OP_MULTU) begin
                        state_d = ST_MUL;
                    end else begin
                        data_out_d = alu_res;
                        zero_d     = (alu_res == '0);
                        overflow_d = alu_ovf;
                        done_d     = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                hi_d       = mul_product[2*WIDTH-1:WIDTH];
                lo_d       = mul_product[WIDTH-1:0];
                data_out_d = mul_product[WIDTH-1:0];
                zero_d     = (mul_product[WIDTH-1:0] == '0);
                overflow_d = 1'b0;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_out_q <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign dataOut  = data_out_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign busy     = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized
// single ops, back-to-back bursts and multiplies, compared against an
// arithmetic reference model with its own HI/LO registers.

module tb_alu_seq;

    localparam int W = 32;

    localparam logic [5:0] C_SRL   = 6'd2;
    localparam logic [5:0] C_MFHI  = 6'd16;
    localparam logic [5:0] C_MFLO  = 6'd18;
    localparam logic [5:0] C_MULTU = 6'd25;
    localparam logic [5:0] C_ADD   = 6'd32;
    localparam logic [5:0] C_SUB   = 6'd34;
    localparam logic [5:0] C_AND   = 6'd36;
    localparam logic [5:0] C_OR    = 6'd37;
    localparam logic [5:0] C_SLT   = 6'd42;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dataA, dataB;
    logic [5:0]   Signal;
    logic [W-1:0] dataOut;
    logic         zero, overflow, busy, done;

    int numChecks = 0;
    int numFails  = 0;

    logic [W-1:0] hiModel, loModel;

    logic [5:0] opList [10] = '{C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SRL,
                                C_MFHI, C_MFLO, 6'h3F, 6'd0};

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dataA    (dataA),
        .dataB    (dataB),
        .Signal   (Signal),
        .dataOut  (dataOut),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Safety net against a stuck simulation
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic, range tests for overflow
    function automatic void modelOp(input logic [5:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] res,
                                    output logic ovf);
        longint sa, sb, s, maxV, minV;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxV = (longint'(1) <<< (W - 1)) - 1;
        minV = -(longint'(1) <<< (W - 1));
        res  = '0;
        ovf  = 1'b0;
        case (op)
            C_ADD: begin
                s   = sa + sb;
                res = W'(s);
                ovf = (s > maxV) || (s < minV);
            end
            C_SUB: begin
                s   = sa - sb;
                res = W'(s);
                ovf = (s > maxV) || (s < minV);
            end
            C_AND:  res = a & b;
            C_OR:   res = a | b;
            C_SLT:  res = (sa < sb) ? W'(1) : W'(0);
            C_SRL:  res = a >> (b % W);
            C_MFHI: res = hiModel;
            C_MFLO: res = loModel;
            default: res = '0;
        endcase
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // One isolated single-cycle op: done in the next cycle only, flags hold after
    task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input string tag);
        logic [W-1:0] expRes;
        logic         expOvf;
        modelOp(op, a, b, expRes, expOvf);
        @(negedge clk);
        start = 1'b1; Signal = op; dataA = a; dataB = b;
        @(negedge clk);
        start = 1'b0; Signal = 6'($urandom); dataA = W'($urandom); dataB = W'($urandom);
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".data"}, dataOut, expRes);
        checkOutput({tag, ".zero"}, zero, expRes == '0);
        checkOutput({tag, ".ovf"}, overflow, expOvf);
        checkOutput({tag, ".busy"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, ".doneLow"}, done, 0);
        checkOutput({tag, ".hold"}, {zero, overflow, dataOut}, {expRes == '0, expOvf, expRes});
    endtask

    // MULTU with optional ignored request at ignoreAt and reset at resetAt
    task automatic runMultu(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int ignoreAt, input int resetAt, input string tag);
        logic [2*W-1:0] p;
        int pulses;
        p = (2*W)'(a) * (2*W)'(b);
        @(negedge clk);
        start = 1'b1; Signal = C_MULTU; dataA = a; dataB = b;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= W; cyc++) begin
            checkOutput({tag, ".busy"}, busy, 1);
            checkOutput({tag, ".noDone"}, done, 0);
            if (resetAt == cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput({tag, ".abortBusy"}, busy, 0);
                checkOutput({tag, ".abortData"}, {zero, dataOut}, {1'b1, {W{1'b0}}});
                pulses = 0;
                for (int k = 0; k < 2 * W; k++) begin
                    if (done === 1'b1) pulses++;
                    @(negedge clk);
                end
                checkOutput({tag, ".abortPulses"}, pulses, 0);
                hiModel = '0;
                loModel = '0;
                return;
            end
            if (ignoreAt == cyc) begin
                start = 1'b1; Signal = C_ADD; dataA = W'(1); dataB = W'(1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput({tag, ".finBusy"}, busy, 0);
        checkOutput({tag, ".finDone"}, done, 0);
        @(negedge clk);
        hiModel = p[2*W-1:W];
        loModel = p[W-1:0];
        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".data"}, dataOut, loModel);
        checkOutput({tag, ".zero"}, zero, loModel == '0);
        checkOutput({tag, ".ovf"}, overflow, 0);
        @(negedge clk);
        checkOutput({tag, ".doneLow"}, done, 0);
    endtask

    // Back-to-back single-cycle ops: one done per request, no gaps
    task automatic burst(input int n);
        logic [5:0]   prevOp;
        logic [W-1:0] prevA, prevB, expRes;
        logic         expOvf;
        prevOp = '0; prevA = '0; prevB = '0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                modelOp(prevOp, prevA, prevB, expRes, expOvf);
                checkOutput("burst.done", done, 1);
                checkOutput("burst.data", dataOut, expRes);
                checkOutput("burst.flags", {zero, overflow}, {expRes == '0, expOvf});
            end
            if (i < n) begin
                prevOp = opList[$urandom_range(0, 9)];
                prevA  = pickOperand();
                prevB  = pickOperand();
                start = 1'b1; Signal = prevOp; dataA = prevA; dataB = prevB;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("burst.doneLow", done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
        hiModel = '0; loModel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset.data", dataOut, 0);
        checkOutput("reset.zero", zero, 1);
        checkOutput("reset.ovf", overflow, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        applyStimulus(C_MFHI, '0, '0, "reset.hi");
        applyStimulus(C_MFLO, '0, '0, "reset.lo");

        applyStimulus(C_ADD, 32'h7FFFFFFF, 32'h00000001, "addOvf");
        applyStimulus(C_SLT, 32'hFFFFFFFF, 32'h00000001, "sltNeg");
        applyStimulus(C_SLT, 32'h80000000, 32'h7FFFFFFF, "sltOvf");
        applyStimulus(C_SLT, 32'h7FFFFFFF, 32'h80000000, "sltPos");
        applyStimulus(C_SUB, 32'd5, 32'd5, "subZero");
        applyStimulus(C_SUB, 32'h80000000, 32'h00000001, "subOvf");

        runMultu(32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, "mulMax");
        applyStimulus(C_MFHI, '0, '0, "mulMax.hi");
        applyStimulus(C_MFLO, '0, '0, "mulMax.lo");

        applyStimulus(C_SRL, 32'h80000000, 32'd31, "srl31");
        applyStimulus(6'h3F, 32'h12345678, 32'h9ABCDEF0, "unknown");
        applyStimulus(C_MFHI, '0, '0, "unknown.hi");
        applyStimulus(C_MFLO, '0, '0, "unknown.lo");

        // Reset and start together: the request is dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; Signal = C_ADD; dataA = W'(1); dataB = W'(1);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("rstStart.done", done, 0);
        checkOutput("rstStart.data", dataOut, 0);
        @(negedge clk);
        checkOutput("rstStart.doneLow", done, 0);
        hiModel = '0; loModel = '0;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(opList[$urandom_range(0, 9)], pickOperand(), pickOperand(), "rand");
        end

        burst(20);

        for (int i = 0; i < 3; i++) begin
            runMultu(pickOperand(), pickOperand(), 0, 0, "randMul");
            applyStimulus(C_MFHI, '0, '0, "randMul.hi");
            applyStimulus(C_MFLO, '0, '0, "randMul.lo");
        end

        runMultu(32'd3, 32'd7, 0, 10, "mulAbort");
        applyStimulus(C_MFLO, '0, '0, "mulAbort.lo");
        applyStimulus(C_MFHI, '0, '0, "mulAbort.hi");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
